// File: rtl/therm_pkg.sv
// Shared types and decode helpers for the thermometer-code modular accumulator.
package therm_pkg;

  localparam int THERM_MAX_W = 32;
  localparam int CNT_MAX_W   = 8;

  typedef struct packed {
    logic [CNT_MAX_W-1:0] count;
    logic                 bubble;
  } s1_word_t;

  function automatic int therm_cw(input int n);
    return $clog2(n + 1);
  endfunction

  // Leading-ones count from bit n-1 down, stopping at the first zero.
  function automatic logic [CNT_MAX_W-1:0] therm_count(input logic [THERM_MAX_W-1:0] word,
                                                       input int n);
    logic [CNT_MAX_W-1:0] cnt;
    logic                 run;
    cnt = {CNT_MAX_W{1'b0}};
    run = 1'b1;
    for (int i = THERM_MAX_W - 1; i >= 0; i--) begin
      if (i < n) begin
        if (word[i] == 1'b0) begin
          run = 1'b0;
        end else if (run) begin
          cnt = cnt + CNT_MAX_W'(1'b1);
        end else begin
          cnt = cnt;
        end
      end else begin
        run = run;
      end
    end
    return cnt;
  endfunction

  function automatic logic therm_bubble(input logic [THERM_MAX_W-1:0] word, input int n);
    logic seen_zero;
    logic bub;
    seen_zero = 1'b0;
    bub       = 1'b0;
    for (int i = THERM_MAX_W - 1; i >= 0; i--) begin
      if (i < n) begin
        if (word[i] == 1'b0) begin
          seen_zero = 1'b1;
        end else if (seen_zero) begin
          bub = 1'b1;
        end else begin
          bub = bub;
        end
      end else begin
        bub = bub;
      end
    end
    return bub;
  endfunction

endpackage

// File: rtl/therm_mod_accum_if.sv
// Control, input-word and result bus of the thermometer-code modular accumulator.
interface therm_mod_accum_if #(
  parameter int N_THERM = 4,
  parameter int W       = 2
);
  logic               clear;
  logic               load_valid;
  logic [W-1:0]       load_value;
  logic               in_valid;
  logic               in_ready;
  logic [N_THERM-1:0] in_therm;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_sum;
  logic               out_wrap;
  logic               out_err;

  modport master (
    output clear, load_valid, load_value, in_valid, in_therm, out_ready,
    input  in_ready, out_valid, out_sum, out_wrap, out_err
  );

  modport slave (
    input  clear, load_valid, load_value, in_valid, in_therm, out_ready,
    output in_ready, out_valid, out_sum, out_wrap, out_err
  );
endinterface

// File: rtl/therm_decode.sv
// Combinational thermometer decoder: leading-ones count plus bubble flag.
// The bubble flag is only built when THERM_BUBBLE_CHECK_EN is defined.
module therm_decode
  import therm_pkg::*;
#(
  parameter int N_THERM = 4
) (
  input  logic [N_THERM-1:0] therm,
  output s1_word_t           word
);

  logic [THERM_MAX_W-1:0] therm_ext_s;

  assign therm_ext_s = THERM_MAX_W'(therm);

  // Decode count and optional bubble flag
  always_comb begin
    word       = '{count: {CNT_MAX_W{1'b0}}, bubble: 1'b0};
    word.count = therm_count(therm_ext_s, N_THERM);
`ifdef THERM_BUBBLE_CHECK_EN
    word.bubble = therm_bubble(therm_ext_s, N_THERM);
`else
    word.bubble = 1'b0;
`endif
  end

endmodule

// File: rtl/therm_mod_accum.sv
// Two-stage thermometer-code modular accumulator with valid/ready flow control,
// load and clear. out_err carries the bubble flag when THERM_BUBBLE_CHECK_EN is defined.
module therm_mod_accum
  import therm_pkg::*;
#(
  parameter int N_THERM = 4,
  parameter int W       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  therm_mod_accum_if.slave  bus
);

  localparam int CW    = therm_cw(N_THERM);
  localparam int SUM_W = ((W > CW) ? W : CW) + 1;

  s1_word_t         dec_word_s;
  logic             s1_valid_r;
  logic [CW-1:0]    s1_count_r;
  logic             s1_bubble_r;
  logic             out_valid_r;
  logic [W-1:0]     out_sum_r;
  logic             out_wrap_r;
  logic             out_err_r;
  logic [W-1:0]     acc_r;
  logic [W-1:0]     base_s;
  logic [SUM_W-1:0] sum_s;
  logic             adv_s;
  logic             accept_s;
  logic             unused_cnt_s;

  therm_decode #(.N_THERM(N_THERM)) u_decode (
    .therm (bus.in_therm),
    .word  (dec_word_s)
  );

  // Count never exceeds N_THERM, so bits above CW are always zero
  assign unused_cnt_s = ^dec_word_s.count[CNT_MAX_W-1:CW];

  // Handshake and sum; a concurrent load replaces the base before the add
  always_comb begin
    adv_s    = s1_valid_r && (!out_valid_r || bus.out_ready);
    accept_s = bus.in_valid && (!s1_valid_r || adv_s) && !bus.clear;
    if (bus.load_valid) begin
      base_s = bus.load_value;
    end else begin
      base_s = acc_r;
    end
    sum_s = SUM_W'(base_s) + SUM_W'(s1_count_r);
  end

  assign bus.in_ready  = !s1_valid_r || adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_wrap  = out_wrap_r;
  assign bus.out_err   = out_err_r;

  // Stage 1: hold the decoded word until stage 2 advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_count_r  <= {CW{1'b0}};
      s1_bubble_r <= 1'b0;
    end else if (bus.clear) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r  <= 1'b1;
      s1_count_r  <= dec_word_s.count[CW-1:0];
      s1_bubble_r <= dec_word_s.bubble;
    end else if (adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: accumulate, register result; outputs hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= {W{1'b0}};
      out_valid_r <= 1'b0;
      out_sum_r   <= {W{1'b0}};
      out_wrap_r  <= 1'b0;
      out_err_r   <= 1'b0;
    end else if (bus.clear) begin
      acc_r       <= {W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (adv_s) begin
      acc_r       <= sum_s[W-1:0];
      out_sum_r   <= sum_s[W-1:0];
      out_wrap_r  <= |sum_s[SUM_W-1:W];
      out_err_r   <= s1_bubble_r;
      out_valid_r <= 1'b1;
    end else begin
      acc_r <= base_s;
      if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_therm_mod_accum.sv
// Randomized scoreboard bench for therm_mod_accum against a leading-ones/modulo reference model.
module tb_therm_mod_accum;

`ifdef THERM_BUBBLE_CHECK_EN
  localparam bit BUB_EN = 1'b1;
`else
  localparam bit BUB_EN = 1'b0;
`endif
  localparam int MOD = 4;

  typedef struct {
    int sum;
    int wrap;
    int err;
    int acc_cyc;
    bit chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   m_acc = 0;
  bit   lat_en = 1'b0;
  bit   rnd_ready_en = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  logic hold_v = 1'b0;
  int   hold_sum, hold_wrap, hold_err;

  always #5 clk = ~clk;

  therm_mod_accum_if #(.N_THERM(4), .W(2)) bus0 ();
  therm_mod_accum_if #(.N_THERM(8), .W(3)) bus8 ();

  therm_mod_accum #(.N_THERM(4), .W(2)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus0));
  therm_mod_accum #(.N_THERM(8), .W(3)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_count(input logic [7:0] w, input int n);
    int c = 0;
    while (c < n && w[n-1-c]) c++;
    return c;
  endfunction

  function automatic bit ref_bubble(input logic [7:0] w, input int n);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += int'(w[i]);
    return ones != ref_count(w, n);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_model(input logic [3:0] w);
    exp_t e;
    int   c, s;
    c = ref_count({4'b0000, w}, 4);
    s = m_acc + c;
    e.sum = s % MOD;
    e.wrap = (s >= MOD) ? 1 : 0;
    e.err = (BUB_EN && ref_bubble({4'b0000, w}, 4)) ? 1 : 0;
    e.acc_cyc = cyc;
    e.chk_lat = lat_en;
    m_acc = s % MOD;
    q.push_back(e);
  endtask

  task automatic send(input logic [3:0] w);
    int waitc = 0;
    bit done = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_therm = w;
    while (!done) begin
      @(negedge clk);
      if (bus0.in_ready && !bus0.clear) begin
        push_model(w);
        done = 1'b1;
      end else begin
        waitc++;
        if (waitc > 50) begin
          check("send_timeout", 0, 1);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    bus0.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rnd_ready_en = 1'b0;
    bus0.out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int v);
    logic [1:0] lv;
    lv = v[1:0];
    bus0.load_valid = 1'b1;
    bus0.load_value = lv;
    @(posedge clk); #1;
    bus0.load_valid = 1'b0;
    m_acc = v % MOD;
  endtask

  task automatic send8(input logic [7:0] w, input int es, input int ew, input int ee);
    int n = 0;
    bus8.in_valid = 1'b1;
    bus8.in_therm = w;
    @(negedge clk);
    check("w8_in_ready", bus8.in_ready, 1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    while (!bus8.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("w8_out_valid", bus8.out_valid, 1);
    check("w8_sum", bus8.out_sum, es);
    check("w8_wrap", bus8.out_wrap, ew);
    check("w8_err", bus8.out_err, ee);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: pops on every transfer, checks hold while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", bus0.out_valid, 1);
        check("hold_sum", bus0.out_sum, hold_sum);
        check("hold_wrap", bus0.out_wrap, hold_wrap);
        check("hold_err", bus0.out_err, hold_err);
      end
      if (bus0.out_valid && bus0.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("sum", bus0.out_sum, mon_e.sum);
          check("wrap", bus0.out_wrap, mon_e.wrap);
          check("err", bus0.out_err, mon_e.err);
          if (mon_e.chk_lat) check("latency", cyc - mon_e.acc_cyc, 2);
        end
      end
      hold_v    <= bus0.out_valid && !bus0.out_ready && !bus0.clear;
      hold_sum  <= int'(bus0.out_sum);
      hold_wrap <= int'(bus0.out_wrap);
      hold_err  <= int'(bus0.out_err);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready_en) bus0.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ones4;
    logic [3:0] w;
    int         tmp;
    ones4 = 4'b1111;
    rst_n = 1'b0;
    bus0.clear = 1'b0; bus0.load_valid = 1'b0; bus0.load_value = 2'd0;
    bus0.in_valid = 1'b0; bus0.in_therm = 4'd0; bus0.out_ready = 1'b1;
    bus8.clear = 1'b0; bus8.load_valid = 1'b0; bus8.load_value = 3'd0;
    bus8.in_valid = 1'b0; bus8.in_therm = 8'd0; bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_out_sum", bus0.out_sum, 0);
    check("rst_out_wrap", bus0.out_wrap, 0);
    check("rst_out_err", bus0.out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_in_ready", bus0.in_ready, 1);
    @(posedge clk); #1;

    // load 3 then count 1 wraps to 0
    lat_en = 1'b1;
    do_load(3);
    send(4'b1000);

    // stream from base 0
    drain();
    do_load(0);
    send(4'b1000);
    send(4'b1100);
    send(4'b1110);
    send(4'b1111);

    // every base x count
    for (int b = 0; b < 4; b++) begin
      for (int c = 1; c <= 4; c++) begin
        drain();
        do_load(b);
        w = ones4 << (4 - c);
        send(w);
      end
    end
    lat_en = 1'b0;

    // backpressure: two accepted, third stalls
    drain();
    bus0.out_ready = 1'b0;
    send(4'b1100);
    send(4'b1110);
    bus0.in_valid = 1'b1;
    bus0.in_therm = 4'b1000;
    repeat (3) @(negedge clk);
    check("stall_in_ready", bus0.in_ready, 0);
    check("stall_out_valid", bus0.out_valid, 1);
    @(posedge clk); #1;
    bus0.out_ready = 1'b1;
    send(4'b1000);
    drain();

    // load concurrent with advance of count 3
    do_load(0);
    bus0.in_valid = 1'b1;
    bus0.in_therm = 4'b1110;
    @(negedge clk);
    check("t4_in_ready", bus0.in_ready, 1);
    mon_e.sum = 1; mon_e.wrap = 1; mon_e.err = 0; mon_e.acc_cyc = cyc; mon_e.chk_lat = 1'b1;
    q.push_back(mon_e);
    m_acc = 1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus0.load_valid = 1'b1;
    bus0.load_value = 2'd2;
    @(posedge clk); #1;
    bus0.load_valid = 1'b0;
    send(4'b1000);
    drain();

    // clear beats load and the incoming word, flushes a pending result
    bus0.out_ready = 1'b0;
    send(4'b1100);
    tmp = 0;
    while (!bus0.out_valid && tmp < 10) begin
      @(negedge clk);
      tmp++;
    end
    @(posedge clk); #1;
    bus0.clear = 1'b1;
    bus0.in_valid = 1'b1;
    bus0.in_therm = 4'b1111;
    bus0.load_valid = 1'b1;
    bus0.load_value = 2'd3;
    q.delete();
    @(posedge clk); #1;
    bus0.clear = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.load_valid = 1'b0;
    m_acc = 0;
    @(negedge clk);
    check("clear_out_valid", bus0.out_valid, 0);
    check("clear_in_ready", bus0.in_ready, 1);
    @(posedge clk); #1;
    bus0.out_ready = 1'b1;
    send(4'b1100);
    drain();

    // bubble words
    do_load(0);
    send(4'b1010);
    send(4'b1100);
    send(4'b0111);
    drain();

    // wide instance: 8-bit thermometer, 3-bit accumulator
    bus8.load_valid = 1'b1;
    bus8.load_value = 3'd7;
    @(posedge clk); #1;
    bus8.load_valid = 1'b0;
    send8(8'hFF, 7, 1, 0);
    send8(8'hF0, 3, 1, 0);
    send8(8'b1010_0000, 4, 0, BUB_EN ? 1 : 0);
    send8(8'h00, 4, 0, 0);

    // randomized stream with random backpressure and occasional loads
    rnd_ready_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        drain();
        do_load(int'($urandom_range(0, 3)));
        rnd_ready_en = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) begin
        w = ones4 << $urandom_range(0, 4);
      end else begin
        tmp = int'($urandom);
        w = tmp[3:0];
      end
      send(w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    // asynchronous reset with words in flight
    do_load(0);
    bus0.out_ready = 1'b0;
    send(4'b1000);
    send(4'b1100);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus0.out_valid, 0);
    check("arst_out_sum", bus0.out_sum, 0);
    check("arst_out_wrap", bus0.out_wrap, 0);
    check("arst_out_err", bus0.out_err, 0);
    check("arst_in_ready", bus0.in_ready, 1);
    q.delete();
    m_acc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    send(4'b1111);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
